fir_sequencer: RTL and testbench
================================

FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 Parameter: SETTLE, default 33, number of WAIT cycles between the fir_ready pulse and result capture; legal values are 33..255.
REQ-002 Port: clock, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port: sample_strobe, input, 1, one-cycle strobe marking a new input sample.
REQ-005 Port: sample_in, input, 8 signed, audio sample, valid while sample_strobe=1.
REQ-006 Port: decim, input, 4, output decimation factor; 0 is treated as 1.
REQ-007 Port: bypass, input, 1, when 1, out_sample carries the raw latched sample instead of the filter result.
REQ-008 Port: clear_overrun, input, 1, clears the sticky overrun flag.
REQ-009 Port: fir_ready, output, 1, one-cycle start pulse to the shared 31-tap FIR engine.
REQ-010 Port: fir_x, output, 8 signed, sample presented to the FIR engine.
REQ-011 Port: fir_y, input, 18 signed, FIR engine result, scaled by 2^10.
REQ-012 Port: out_valid, output, 1, one-cycle pulse marking that out_sample is new.
REQ-013 Port: out_sample, output, 8 signed, decimated filtered (or bypassed) sample.
REQ-014 Port: busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 Port: overrun, output, 1, sticky flag indicating a sample was dropped.

Function
REQ-016 The FSM SHALL have four states, IDLE, ISSUE, WAIT and CAPTURE, with these transitions: IDLE->ISSUE on sample_strobe; ISSUE->WAIT unconditionally; WAIT->CAPTURE after exactly SETTLE cycles in WAIT; CAPTURE->IDLE unconditionally.
REQ-017 On accepting sample_strobe in IDLE, the block SHALL latch sample_in into fir_x, and fir_x SHALL hold that value until the next accepted strobe.
REQ-018 fir_ready SHALL be a registered output that is high only during the single ISSUE cycle, so that at least SETTLE+2 low cycles separate consecutive pulses.
REQ-019 Every accepted sample SHALL be issued to the FIR engine regardless of decim or bypass, so the filter history stays complete.
REQ-020 A 4-bit phase counter SHALL be evaluated in CAPTURE: if phase=0, deliver the result and reload phase with max(decim,1)-1; otherwise decrement phase and deliver nothing.
REQ-021 A change to decim SHALL take effect only at the next phase reload.
REQ-022 Delivery SHALL register out_sample = fir_y[17:10] (arithmetic truncation, no rounding or saturation), or the latched sample when bypass=1 (bypass sampled in CAPTURE), and SHALL pulse out_valid for one cycle.
REQ-023 Latency SHALL be fixed: for a strobe sampled high in cycle c, fir_ready is high in cycle c+1, CAPTURE occurs in cycle c+2+SETTLE, and out_valid is high in cycle c+3+SETTLE (c+36 at the default SETTLE).
REQ-024 out_sample SHALL hold its value between deliveries.
REQ-025 A sample_strobe arriving in any state other than IDLE (including CAPTURE) SHALL be dropped: no latch, no state change, and overrun set to 1.
REQ-026 overrun SHALL remain 1 until clear_overrun=1 in a cycle with no new drop; if a drop and clear_overrun occur in the same cycle, overrun SHALL end that cycle at 1 (set wins).
REQ-027 The minimum lossless strobe spacing SHALL be SETTLE+3 cycles.
REQ-028 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-029 While reset_n=0, the block SHALL asynchronously force: state=IDLE, fir_ready=0, fir_x=0, out_valid=0, out_sample=0, overrun=0, phase=0, and the WAIT counter=0.
REQ-030 Reset asserted mid-operation SHALL abort the sample in flight, and no out_valid SHALL follow for it.
REQ-031 After reset release, the first accepted sample SHALL be delivered (phase=0).

Verification
REQ-032 Scenario, basic path: decim=1, bypass=0, strobe with sample_in=8'sd100, FIR model drives fir_y=18'sd25600 -> fir_ready high one cycle at c+1 with fir_x=100; out_valid at c+36 with out_sample=8'sd25.
REQ-033 Scenario, decimation: decim=3, six strobes 40 cycles apart -> six fir_ready pulses; out_valid only after the 1st and 4th results.
REQ-034 Scenario, overrun: second strobe 10 cycles after the first -> no second fir_ready and overrun=1; clear_overrun pulse -> overrun=0; drop in the same cycle as clear_overrun -> overrun=1.
REQ-035 Scenario, bypass: bypass=1 with sample_in=-8'sd7 -> fir_ready still pulses; out_valid at c+36 with out_sample=-8'sd7.
REQ-036 Scenario, reset mid-WAIT: reset_n=0 during WAIT -> all outputs 0 immediately, and no out_valid after release; the next strobe is delivered at c+36.
REQ-037 Scenario, decim=0: decim=0 with three strobes -> three out_valid pulses, identical to decim=1.

Source files
------------

// File: rtl/fir_sequencer_if.sv
// Signal bundle between the FIR sequencer and its surroundings: the sample
// source, the shared FIR engine handshake and the decimated output stream.
interface fir_sequencer_if;
    logic               sample_strobe;
    logic signed [7:0]  sample_in;
    logic [3:0]         decim;
    logic               bypass;
    logic               clear_overrun;
    logic               fir_ready;
    logic signed [7:0]  fir_x;
    logic signed [17:0] fir_y;
    logic               out_valid;
    logic signed [7:0]  out_sample;
    logic               busy;
    logic               overrun;

    modport master (
        output sample_strobe, sample_in, decim, bypass, clear_overrun, fir_y,
        input  fir_ready, fir_x, out_valid, out_sample, busy, overrun
    );

    modport slave (
        input  sample_strobe, sample_in, decim, bypass, clear_overrun, fir_y,
        output fir_ready, fir_x, out_valid, out_sample, busy, overrun
    );
endinterface

// File: rtl/fir_sequencer.sv
// Sequences single samples through a shared 31-tap FIR engine, waits a fixed
// settle time, then delivers decimated (or bypassed) results.
module fir_sequencer #(
    parameter int SETTLE = 33
) (
    input  logic            clock,
    input  logic            reset_n,
    fir_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [7:0] W_LAST = 8'(SETTLE - 1);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_wait_cnt;
    logic [3:0]         r_phase;
    logic               r_fir_ready;
    logic signed [7:0]  r_fir_x;
    logic               r_out_valid;
    logic signed [7:0]  r_out_sample;
    logic               r_overrun;
    logic               w_accept;
    logic               w_drop;
    logic               w_deliver;
    logic [3:0]         w_reload;

    // Engine output is Q.10; keep the integer part, floor toward -inf.
    function automatic logic signed [7:0] f_trunc(input logic signed [17:0] y);
        return 8'(y >>> 10);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_drop    = 1'b0;
        w_deliver = 1'b0;
        w_reload  = (bus.decim == 4'd0) ? 4'd0 : 4'(bus.decim - 4'd1);
        case (r_state)
            S_IDLE: begin
                if (bus.sample_strobe) begin
                    w_next   = S_ISSUE;
                    w_accept = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
                w_drop = bus.sample_strobe;
            end
            S_WAIT: begin
                if (r_wait_cnt == W_LAST) begin
                    w_next = S_CAPTURE;
                end
                w_drop = bus.sample_strobe;
            end
            S_CAPTURE: begin
                w_next    = S_IDLE;
                w_drop    = bus.sample_strobe;
                w_deliver = (r_phase == 4'd0);
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt   <= 8'd0;
            r_phase      <= 4'd0;
            r_fir_ready  <= 1'b0;
            r_fir_x      <= 8'sd0;
            r_out_valid  <= 1'b0;
            r_out_sample <= 8'sd0;
            r_overrun    <= 1'b0;
        end else begin
            r_fir_ready <= w_accept;
            r_out_valid <= w_deliver;
            if (w_accept) begin
                r_fir_x <= bus.sample_in;
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= 8'd0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Decimation: only phase 0 delivers; a new decim lands at reload.
            if (r_state == S_CAPTURE) begin
                if (r_phase == 4'd0) begin
                    r_phase      <= w_reload;
                    r_out_sample <= bus.bypass ? r_fir_x : f_trunc(bus.fir_y);
                end else begin
                    r_phase <= r_phase - 4'd1;
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.fir_ready  = r_fir_ready;
    assign bus.fir_x      = r_fir_x;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sample = r_out_sample;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: latency, truncation, decimation, bypass,
// overrun stickiness and asynchronous reset abort.
module tb_fir_sequencer;

    logic clock = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    fir_sequencer_if bus ();

    fir_sequencer #(.SETTLE(33)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, wanted %0d", tag, act, exp);
        end
    endtask

    // Returns at the falling edge of the cycle after the strobe (fir_ready cycle).
    task automatic strobe(input logic signed [7:0] s);
        @(negedge clock);
        bus.sample_strobe = 1'b1;
        bus.sample_in     = s;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
    endtask

    task automatic run_sample(input string tag, input logic signed [7:0] s,
                              input logic signed [17:0] y, input bit exp_vld,
                              input logic signed [7:0] exp_out);
        int nrdy;
        int vld_at;
        logic signed [7:0] got;
        bus.fir_y = y;
        strobe(s);
        chk({tag, ".rdy"}, int'(bus.fir_ready), 1);
        chk({tag, ".x"}, int'(bus.fir_x), int'(s));
        nrdy   = 1;
        vld_at = -1;
        got    = 8'sd0;
        for (int rel = 2; rel <= 40; rel++) begin
            @(negedge clock);
            if (bus.fir_ready) nrdy++;
            if (bus.out_valid && vld_at < 0) begin
                vld_at = rel;
                got    = bus.out_sample;
            end
        end
        chk({tag, ".nrdy"}, nrdy, 1);
        chk({tag, ".lat"}, vld_at, exp_vld ? 36 : -1);
        if (exp_vld) begin
            chk({tag, ".out"}, int'(got), int'(exp_out));
            chk({tag, ".hold"}, int'(bus.out_sample), int'(exp_out));
        end
        chk({tag, ".idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        int nrdy;
        int nvld;
        logic signed [7:0] got;

        reset_n           = 1'b0;
        bus.sample_strobe = 1'b0;
        bus.sample_in     = 8'sd0;
        bus.decim         = 4'd1;
        bus.bypass        = 1'b0;
        bus.clear_overrun = 1'b0;
        bus.fir_y         = 18'sd0;
        repeat (3) @(negedge clock);
        chk("rst.rdy", int'(bus.fir_ready), 0);
        chk("rst.x", int'(bus.fir_x), 0);
        chk("rst.vld", int'(bus.out_valid), 0);
        chk("rst.out", int'(bus.out_sample), 0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.ovr", int'(bus.overrun), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Basic path and truncation corners
        run_sample("basic", 8'sd100, 18'sd25600, 1'b1, 8'sd25);
        run_sample("negone", -8'sd3, -18'sd1, 1'b1, -8'sd1);
        run_sample("frac", 8'sd4, 18'sd1023, 1'b1, 8'sd0);
        run_sample("negfl", -8'sd9, -18'sd1025, 1'b1, -8'sd2);
        run_sample("max", 8'sd127, 18'sd131071, 1'b1, 8'sd127);
        run_sample("min", -8'sd128, -18'sd131072, 1'b1, -8'sd128);

        // Decimation by 3: deliveries after the 1st and 4th results only
        bus.decim = 4'd3;
        for (int i = 0; i < 6; i++) begin
            run_sample($sformatf("dec3.%0d", i), 8'(i + 1),
                       18'(i * 1024 + 300), (i == 0) || (i == 3), 8'(i));
        end

        // decim = 0 behaves as 1
        bus.decim = 4'd0;
        for (int i = 0; i < 3; i++) begin
            run_sample($sformatf("dec0.%0d", i), 8'(10 + i),
                       18'((20 + i) * 1024), 1'b1, 8'(20 + i));
        end
        bus.decim = 4'd1;

        // Bypass
        bus.bypass = 1'b1;
        run_sample("byp", -8'sd7, 18'sd25600, 1'b1, -8'sd7);
        bus.bypass = 1'b0;

        // Overrun: drop during WAIT
        bus.fir_y = 18'sd5120;
        strobe(8'sd11);
        repeat (8) @(negedge clock);
        bus.sample_strobe = 1'b1;
        bus.sample_in     = 8'sd99;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        chk("ovr.set", int'(bus.overrun), 1);
        chk("ovr.x", int'(bus.fir_x), 11);
        chk("ovr.busy", int'(bus.busy), 1);
        nrdy = 0;
        nvld = 0;
        got  = 8'sd0;
        for (int rel = 11; rel <= 40; rel++) begin
            @(negedge clock);
            if (bus.fir_ready) nrdy++;
            if (bus.out_valid) begin
                nvld++;
                got = bus.out_sample;
            end
        end
        chk("ovr.nrdy", nrdy, 0);
        chk("ovr.nvld", nvld, 1);
        chk("ovr.out", int'(got), 5);
        chk("ovr.sticky", int'(bus.overrun), 1);
        @(negedge clock);
        bus.clear_overrun = 1'b1;
        @(negedge clock);
        bus.clear_overrun = 1'b0;
        chk("ovr.clr", int'(bus.overrun), 0);

        // Drop coinciding with clear: set wins
        strobe(8'sd12);
        repeat (4) @(negedge clock);
        bus.sample_strobe = 1'b1;
        bus.clear_overrun = 1'b1;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        bus.clear_overrun = 1'b0;
        chk("ovr.both", int'(bus.overrun), 1);

        // Reset mid-WAIT aborts the sample in flight
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid.rdy", int'(bus.fir_ready), 0);
        chk("mid.x", int'(bus.fir_x), 0);
        chk("mid.vld", int'(bus.out_valid), 0);
        chk("mid.out", int'(bus.out_sample), 0);
        chk("mid.busy", int'(bus.busy), 0);
        chk("mid.ovr", int'(bus.overrun), 0);
        @(negedge clock);
        reset_n = 1'b1;
        nrdy = 0;
        nvld = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.fir_ready) nrdy++;
            if (bus.out_valid) nvld++;
        end
        chk("mid.nrdy", nrdy, 0);
        chk("mid.nvld", nvld, 0);
        run_sample("mid.next", 8'sd50, -18'sd20480, 1'b1, -8'sd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
